// File: rtl/cross_bar_nxm.sv
// N-host x M-agent crossbar with one round-robin arbiter per agent and a per-host read capture register.
// Optional per-agent grant watchdog: define CROSS_BAR_NXM_TIMEOUT_EN.
module cross_bar_nxm #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int N_HOST  = 4,
  parameter int N_AGENT = 4,
  parameter int QUANTUM = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [N_HOST-1:0]                     req_i,
  input  logic [N_HOST-1:0]                     cmd_i,
  input  logic [N_HOST*AW-1:0]                  addr_i,
  input  logic [N_HOST*DW-1:0]                  wdata_i,
  input  logic [N_HOST-1:0]                     resp_i,
  output logic [N_HOST*DW-1:0]                  rdata_o,
  output logic [N_HOST-1:0]                     ack_o,
  input  logic [N_AGENT-1:0]                    ack_i,
  output logic [N_AGENT-1:0]                    req_o,
  output logic [N_AGENT-1:0]                    cmd_o,
  output logic [N_AGENT*AW-1:0]                 addr_o,
  input  logic [N_AGENT*DW-1:0]                 agent_word_i,
  output logic [N_AGENT*DW-1:0]                 host_word_o,
  output logic [N_HOST-1:0]                     err_o,
  output logic [N_AGENT-1:0]                    dbg_grant_o,
  output logic [N_AGENT*$clog2(N_HOST)-1:0]     dbg_owner_o
);
  localparam int HW  = $clog2(N_HOST);
  localparam int AGW = $clog2(N_AGENT);
  localparam int CW  = $clog2(QUANTUM + 1);

  if (N_HOST < 2 || N_AGENT < 2 || QUANTUM < 1 || TIMEOUT < 1) begin : g_param_check
    $error("cross_bar_nxm: illegal parameter combination");
  end

  // Handshake: a transfer completes on any cycle where req_o[a] and ack_i[a] are both high;
  // ack_o[owner] mirrors ack_i[a] combinationally in that same cycle.
  logic [N_HOST-1:0]  w_want      [N_AGENT];
  logic [N_AGENT-1:0] r_busy, w_busy_nxt;
  logic [HW-1:0]      r_owner     [N_AGENT];
  logic [HW-1:0]      w_owner_nxt [N_AGENT];
  logic [HW-1:0]      r_ptr       [N_AGENT];
  logic [HW-1:0]      w_ptr_nxt   [N_AGENT];
  logic [CW-1:0]      r_cnt       [N_AGENT];
  logic [CW-1:0]      w_cnt_nxt   [N_AGENT];
  logic [DW-1:0]      r_rdata     [N_HOST];
`ifdef CROSS_BAR_NXM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]      r_wdog      [N_AGENT];
  logic [TW-1:0]      w_wdog_nxt  [N_AGENT];
  logic [N_HOST-1:0]  r_err, w_err_nxt;
`endif

  // First set bit of v at or after start, cyclically; MSB flags whether one was found.
  function automatic logic [HW:0] pick(input logic [N_HOST-1:0] v, input logic [HW-1:0] start);
    logic [HW:0] res;
    res = '0;
    for (int i = 0; i < N_HOST; i++) begin
      int j;
      j = int'(start) + i;
      if (j >= N_HOST) j = j - N_HOST;
      if (!res[HW] && v[j]) res = {1'b1, HW'(j)};
    end
    return res;
  endfunction

  always_comb begin
    for (int a = 0; a < N_AGENT; a++) begin
      for (int h = 0; h < N_HOST; h++) begin
        w_want[a][h] = req_i[h] && (addr_i[h*AW + AW-1 -: AGW] == AGW'(a));
      end
    end
  end

  // Arbiter next-state: IDLE (r_busy=0) or GRANT(owner, cnt).
  always_comb begin : p_next
    logic [HW:0]       v_pick;
    logic [CW-1:0]     v_cnt_inc;
    logic [N_HOST-1:0] v_others;
    logic [HW-1:0]     v_ptr;
    logic              v_quota, v_tmo, v_rel;
    v_pick = '0; v_cnt_inc = '0; v_others = '0; v_ptr = '0;
    v_quota = 1'b0; v_tmo = 1'b0; v_rel = 1'b0;
`ifdef CROSS_BAR_NXM_TIMEOUT_EN
    w_err_nxt = '0;
`endif
    for (int a = 0; a < N_AGENT; a++) begin
      w_busy_nxt[a]  = r_busy[a];
      w_owner_nxt[a] = r_owner[a];
      w_ptr_nxt[a]   = r_ptr[a];
      w_cnt_nxt[a]   = r_cnt[a];
`ifdef CROSS_BAR_NXM_TIMEOUT_EN
      w_wdog_nxt[a]  = '0;
`endif
      if (!r_busy[a]) begin
        v_pick = pick(w_want[a], r_ptr[a]);
        if (v_pick[HW]) begin
          w_busy_nxt[a]  = 1'b1;
          w_owner_nxt[a] = v_pick[HW-1:0];
          w_cnt_nxt[a]   = '0;
        end
      end else begin
        v_cnt_inc = r_cnt[a] + CW'(ack_i[a]);
        v_others  = w_want[a] & ~(N_HOST'(1) << r_owner[a]);
        v_quota   = ack_i[a] && (v_cnt_inc == CW'(QUANTUM));
        v_tmo     = 1'b0;
`ifdef CROSS_BAR_NXM_TIMEOUT_EN
        v_tmo         = !ack_i[a] && (r_wdog[a] == TW'(TIMEOUT - 1));
        w_wdog_nxt[a] = ack_i[a] ? '0 : r_wdog[a] + 1'b1;
`endif
        v_rel = !w_want[a][r_owner[a]] || (v_quota && |v_others) || v_tmo;
        if (v_rel) begin
          v_ptr  = (r_owner[a] == HW'(N_HOST - 1)) ? '0 : r_owner[a] + 1'b1;
          v_pick = pick(v_others, v_ptr);
          w_ptr_nxt[a]   = v_ptr;
          w_busy_nxt[a]  = v_pick[HW];
          w_owner_nxt[a] = v_pick[HW] ? v_pick[HW-1:0] : r_owner[a];
          w_cnt_nxt[a]   = '0;
`ifdef CROSS_BAR_NXM_TIMEOUT_EN
          w_wdog_nxt[a]  = '0;
          if (v_tmo) w_err_nxt[r_owner[a]] = 1'b1;
`endif
        end else begin
          w_cnt_nxt[a] = v_quota ? '0 : v_cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_busy <= '0;
      for (int a = 0; a < N_AGENT; a++) begin
        r_owner[a] <= '0;
        r_ptr[a]   <= '0;
        r_cnt[a]   <= '0;
`ifdef CROSS_BAR_NXM_TIMEOUT_EN
        r_wdog[a]  <= '0;
`endif
      end
      for (int h = 0; h < N_HOST; h++) r_rdata[h] <= '0;
`ifdef CROSS_BAR_NXM_TIMEOUT_EN
      r_err <= '0;
`endif
    end else begin
      r_busy <= w_busy_nxt;
      for (int a = 0; a < N_AGENT; a++) begin
        r_owner[a] <= w_owner_nxt[a];
        r_ptr[a]   <= w_ptr_nxt[a];
        r_cnt[a]   <= w_cnt_nxt[a];
`ifdef CROSS_BAR_NXM_TIMEOUT_EN
        r_wdog[a]  <= w_wdog_nxt[a];
`endif
        if (r_busy[a] && ack_i[a] && !cmd_i[r_owner[a]]) begin
          r_rdata[r_owner[a]] <= agent_word_i[a*DW +: DW];
        end
      end
`ifdef CROSS_BAR_NXM_TIMEOUT_EN
      r_err <= w_err_nxt;
`endif
    end
  end

  always_comb begin
    req_o = '0; cmd_o = '0; addr_o = '0; host_word_o = '0; ack_o = '0; dbg_owner_o = '0;
    for (int a = 0; a < N_AGENT; a++) begin
      dbg_owner_o[a*HW +: HW] = r_owner[a];
      if (r_busy[a]) begin
        req_o[a]                  = 1'b1;
        cmd_o[a]                  = cmd_i[r_owner[a]];
        addr_o[a*AW +: AW]        = addr_i[r_owner[a]*AW +: AW];
        host_word_o[a*DW +: DW]   = wdata_i[r_owner[a]*DW +: DW];
        if (ack_i[a] && !reset_i) ack_o[r_owner[a]] = 1'b1;
      end
    end
    for (int h = 0; h < N_HOST; h++) begin
      rdata_o[h*DW +: DW] = resp_i[h] ? r_rdata[h] : '0;
    end
  end

  assign dbg_grant_o = r_busy;
`ifdef CROSS_BAR_NXM_TIMEOUT_EN
  assign err_o = r_err;
`else
  assign err_o = '0;
`endif
endmodule
